// File: rtl/imem_pipelined.sv
// Byte-addressed little-endian instruction memory with a valid/ready fetch
// port (latency 1 or 2, backpressure hold, flush) and a byte-enabled load port.
// Ports:
//   clk, rst                      clock, async active-high reset
//   fetch_req_valid/ready         request handshake
//   fetch_addr                    request byte address
//   fetch_flush                   drop everything in flight and held
//   fetch_rsp_valid/ready         response handshake
//   fetch_rsp_data/addr/fault     response word, echoed address, fault flag
//   load_en/addr/data/be          program-load write port
//   load_err                      one-cycle pulse after an out-of-range load
module imem_pipelined #(
  parameter int          ADDR_W      = 32,
  parameter int          DEPTH_BYTES = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_rsp_valid,
  input  logic              fetch_rsp_ready,
  output logic [31:0]       fetch_rsp_data,
  output logic [ADDR_W-1:0] fetch_rsp_addr,
  output logic              fetch_rsp_fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic [3:0]        load_be,
  output logic              load_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_BYTES - 4);

  logic [7:0] mem [DEPTH_BYTES];

  logic              stall;
  logic              accept;
  logic              rd_fault;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_data;

  assign stall           = fetch_rsp_valid && !fetch_rsp_ready;
  assign fetch_req_ready = !stall && !fetch_flush;
  assign accept          = fetch_req_valid && fetch_req_ready;

  assign rd_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST);

  // A faulting address never reaches the array index.
  assign rd_idx  = rd_fault ? '0 : fetch_addr[IDX_W-1:0];
  assign rd_data = rd_fault ? NOP_INSTR :
                   {mem[rd_idx + IDX_W'(3)], mem[rd_idx + IDX_W'(2)],
                    mem[rd_idx + IDX_W'(1)], mem[rd_idx]};

  logic [ADDR_W-1:0] ld_word;
  logic              ld_oor;
  logic [IDX_W-1:0]  ld_idx;

  assign ld_word = load_addr & ~ADDR_W'(3);
  assign ld_oor  = ld_word > LAST;
  assign ld_idx  = ld_oor ? '0 : ld_word[IDX_W-1:0];

  // Storage has no reset so reset leaves the loaded program intact.
  always_ff @(posedge clk) begin
    if (load_en && !ld_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (load_be[i]) begin
          mem[ld_idx + IDX_W'(i)] <= load_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load_en && ld_oor;
    end
  end

  // Entry offered to the output register this cycle.
  logic              in_valid;
  logic              in_fault;
  logic [31:0]       in_data;
  logic [ADDR_W-1:0] in_addr;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign in_valid = accept;
      assign in_fault = rd_fault;
      assign in_data  = rd_data;
      assign in_addr  = fetch_addr;
    end else begin : g_lat2
      logic              s1_valid;
      logic              s1_fault;
      logic [31:0]       s1_data;
      logic [ADDR_W-1:0] s1_addr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_fault <= 1'b0;
          s1_data  <= '0;
          s1_addr  <= '0;
        end else if (fetch_flush) begin
          s1_valid <= 1'b0;
        end else if (!stall) begin
          s1_valid <= accept;
          if (accept) begin
            s1_fault <= rd_fault;
            s1_data  <= rd_data;
            s1_addr  <= fetch_addr;
          end
        end
      end

      assign in_valid = s1_valid;
      assign in_fault = s1_fault;
      assign in_data  = s1_data;
      assign in_addr  = s1_addr;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_rsp_valid <= 1'b0;
      fetch_rsp_fault <= 1'b0;
      fetch_rsp_data  <= '0;
      fetch_rsp_addr  <= '0;
    end else if (fetch_flush) begin
      fetch_rsp_valid <= 1'b0;
    end else if (!stall) begin
      fetch_rsp_valid <= in_valid;
      if (in_valid) begin
        fetch_rsp_fault <= in_fault;
        fetch_rsp_data  <= in_data;
        fetch_rsp_addr  <= in_addr;
      end
    end
  end

endmodule

// File: tb/tb_imem_pipelined.sv
// Bench for imem_pipelined: LATENCY=1 and LATENCY=2 instances checked
// cycle by cycle against a shift-pipeline and byte-array reference model.
module tb_imem_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        rqv [2];
  logic        rqr [2];
  logic [31:0] fa  [2];
  logic        fl  [2];
  logic        rsv [2];
  logic        rsr [2];
  logic [31:0] rsd [2];
  logic [31:0] rsa [2];
  logic        rsf [2];
  logic        len;
  logic [31:0] laddr;
  logic [31:0] ldata;
  logic [3:0]  lbe;
  logic        lerr [2];

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  imem_pipelined #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .fetch_req_valid(rqv[0]), .fetch_req_ready(rqr[0]),
    .fetch_addr(fa[0]), .fetch_flush(fl[0]),
    .fetch_rsp_valid(rsv[0]), .fetch_rsp_ready(rsr[0]),
    .fetch_rsp_data(rsd[0]), .fetch_rsp_addr(rsa[0]),
    .fetch_rsp_fault(rsf[0]),
    .load_en(len), .load_addr(laddr), .load_data(ldata),
    .load_be(lbe), .load_err(lerr[0])
  );

  imem_pipelined #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .fetch_req_valid(rqv[1]), .fetch_req_ready(rqr[1]),
    .fetch_addr(fa[1]), .fetch_flush(fl[1]),
    .fetch_rsp_valid(rsv[1]), .fetch_rsp_ready(rsr[1]),
    .fetch_rsp_data(rsd[1]), .fetch_rsp_addr(rsa[1]),
    .fetch_rsp_fault(rsf[1]),
    .load_en(len), .load_addr(laddr), .load_data(ldata),
    .load_be(lbe), .load_err(lerr[1])
  );

  // Reference model: byte array plus a LATENCY-deep slot pipeline.
  logic [7:0]  mm [1024];
  bit          mv [2][2];
  logic [31:0] ma [2][2];
  logic [31:0] md [2][2];
  bit          mf [2][2];
  bit          exp_lerr;
  int          lat [2] = '{1, 2};

  logic [31:0] sq [2][2048];
  int          sh [2];
  int          st [2];
  logic [31:0] ob [2][2048];
  int          on [2];

  function automatic bit mfault(input logic [31:0] a);
    return (a % 4 != 0) || (a > 32'd1020);
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    if (mfault(a)) return 32'h00000013;
    return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
  endfunction

  task automatic push(input int d, input logic [31:0] a);
    sq[d][st[d]] = a;
    st[d]++;
  endtask

  // One clock: present queued requests, score ready before the edge,
  // advance the model at the edge, score outputs just after it.
  task automatic step();
    bit er [2];
    bit acc [2];
    bit stl [2];
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rqv[d] = (sh[d] != st[d]);
      if (rqv[d]) fa[d] = sq[d][sh[d]];
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      stl[d] = mv[d][lat[d]-1] && !rsr[d];
      er[d]  = !stl[d] && !fl[d];
      nchk++;
      if (rqr[d] !== er[d]) begin
        nfail++;
        $display("FAIL ready[%0d] got=%b exp=%b t=%0t", d, rqr[d], er[d], $time);
      end
      if (rsv[d] === 1'b1 && rsr[d] && on[d] < 2048) begin
        ob[d][on[d]] = rsa[d];
        on[d]++;
      end
      acc[d] = rqv[d] && er[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (fl[d]) begin
        mv[d][0] = 0;
        mv[d][1] = 0;
      end else if (!stl[d]) begin
        for (int k = lat[d] - 1; k > 0; k--) begin
          mv[d][k] = mv[d][k-1];
          ma[d][k] = ma[d][k-1];
          md[d][k] = md[d][k-1];
          mf[d][k] = mf[d][k-1];
        end
        mv[d][0] = acc[d];
        if (acc[d]) begin
          a = fa[d];
          ma[d][0] = a;
          mf[d][0] = mfault(a);
          md[d][0] = mword(a);
        end
      end
      if (acc[d]) sh[d]++;
    end
    exp_lerr = 0;
    if (len) begin
      a = laddr & 32'hFFFFFFFC;
      if (a > 32'd1020) begin
        exp_lerr = 1;
      end else begin
        for (int i = 0; i < 4; i++)
          if (lbe[i]) mm[a+i] = ldata[8*i +: 8];
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if (rsv[d] !== mv[d][lat[d]-1]) begin
        nfail++;
        $display("FAIL rsp_valid[%0d] got=%b exp=%b t=%0t", d, rsv[d],
                 mv[d][lat[d]-1], $time);
      end
      if (mv[d][lat[d]-1]) begin
        nchk++;
        if ({rsd[d], rsa[d], rsf[d]} !==
            {md[d][lat[d]-1], ma[d][lat[d]-1], mf[d][lat[d]-1]}) begin
          nfail++;
          $display("FAIL rsp[%0d] got=%h/%h/%b exp=%h/%h/%b t=%0t", d,
                   rsd[d], rsa[d], rsf[d], md[d][lat[d]-1],
                   ma[d][lat[d]-1], mf[d][lat[d]-1], $time);
        end
      end
      nchk++;
      if (lerr[d] !== exp_lerr) begin
        nfail++;
        $display("FAIL load_err[%0d] got=%b exp=%b t=%0t", d, lerr[d],
                 exp_lerr, $time);
      end
    end
    len = 1'b0;
    fl[0] = 1'b0;
    fl[1] = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] be);
    len = 1'b1;
    laddr = a;
    ldata = v;
    lbe = be;
    step();
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d][0] = 0;
      mv[d][1] = 0;
      sh[d] = 0;
      st[d] = 0;
      on[d] = 0;
    end
    exp_lerr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    len = 1'b0; laddr = '0; ldata = '0; lbe = '0;
    for (int d = 0; d < 2; d++) begin
      rqv[d] = 0; fa[d] = '0; fl[d] = 0; rsr[d] = 1;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({rsv[d], rsd[d], rsa[d], rsf[d], lerr[d], rqr[d]} !==
          {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
        nfail++;
        $display("FAIL reset_state[%0d] got=%b/%h/%h/%b/%b/%b", d, rsv[d],
                 rsd[d], rsa[d], rsf[d], lerr[d], rqr[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    for (int w = 0; w < 256; w++) do_load(w * 4, $urandom, 4'hF);
  endtask

  task automatic test_basic();
    do_load(32'h0, 32'h00c00093, 4'hF);
    do_load(32'h4, 32'h01000113, 4'hF);
    push(0, 32'h0);
    push(0, 32'h4);
    step();
    nchk++;
    if ({rsv[0], rsd[0], rsa[0], rsf[0]} !== {1'b1, 32'h00c00093, 32'h0, 1'b0}) begin
      nfail++;
      $display("FAIL basic_w0 got=%b/%h/%h/%b", rsv[0], rsd[0], rsa[0], rsf[0]);
    end
    step();
    nchk++;
    if ({rsv[0], rsd[0], rsa[0], rsf[0]} !== {1'b1, 32'h01000113, 32'h4, 1'b0}) begin
      nfail++;
      $display("FAIL basic_w1 got=%b/%h/%h/%b", rsv[0], rsd[0], rsa[0], rsf[0]);
    end
    step();
  endtask

  task automatic test_byte_enable();
    do_load(32'h8, 32'h11223344, 4'hF);
    do_load(32'h8, 32'hAABBCCDD, 4'b0101);
    push(0, 32'h8);
    push(1, 32'h8);
    step();
    nchk++;
    if (rsd[0] !== 32'h11BB33DD || rsv[1] !== 1'b0) begin
      nfail++;
      $display("FAIL byte_en_l1 got=%h v2=%b exp=11bb33dd v2=0", rsd[0], rsv[1]);
    end
    step();
    nchk++;
    if (rsd[1] !== 32'h11BB33DD || rsv[1] !== 1'b1) begin
      nfail++;
      $display("FAIL byte_en_l2 got=%h v=%b exp=11bb33dd v=1", rsd[1], rsv[1]);
    end
    step();
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4] = '{32'h6, 32'h400, 32'h80000000, 32'h3FC};
    bit          fexp  [4] = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      push(0, addrs[i]);
      step();
      nchk++;
      if (rsf[0] !== fexp[i] ||
          (fexp[i] && rsd[0] !== 32'h00000013)) begin
        nfail++;
        $display("FAIL fault_%h got=%b/%h exp_fault=%b", addrs[i], rsf[0],
                 rsd[0], fexp[i]);
      end
    end
    do_load(32'h400, 32'hDEADBEEF, 4'hF);
    nchk++;
    if (lerr[0] !== 1'b1 || lerr[1] !== 1'b1) begin
      nfail++;
      $display("FAIL load_err_pulse got=%b%b exp=11", lerr[0], lerr[1]);
    end
    do_load(32'h401, 32'hDEADBEEF, 4'hF);
    step();
    nchk++;
    if (lerr[0] !== 1'b0) begin
      nfail++;
      $display("FAIL load_err_clear got=%b exp=0", lerr[0]);
    end
    push(0, 32'h0);
    step();
    nchk++;
    if (rsd[0] !== 32'h00c00093) begin
      nfail++;
      $display("FAIL oor_no_write got=%h exp=00c00093", rsd[0]);
    end
    step();
  endtask

  task automatic test_back_to_back(input int d);
    logic [31:0] hold;
    on[d] = 0;
    rsr[d] = 1'b0;
    push(d, 32'h10);
    push(d, 32'h14);
    push(d, 32'h18);
    step();
    if (d == 1) begin
      nchk++;
      if (rsv[1] !== 1'b0) begin
        nfail++;
        $display("FAIL l2_latency_early got=%b exp=0", rsv[1]);
      end
      step();
    end
    nchk++;
    if ({rsv[d], rsa[d], rqr[d]} !== {1'b1, 32'h10, 1'b0}) begin
      nfail++;
      $display("FAIL b2b_first[%0d] got=%b/%h/%b exp=1/10/0", d, rsv[d],
               rsa[d], rqr[d]);
    end
    hold = rsd[d];
    step();
    step();
    nchk++;
    if ({rsv[d], rsd[d], rsa[d], rqr[d]} !== {1'b1, hold, 32'h10, 1'b0}) begin
      nfail++;
      $display("FAIL b2b_hold[%0d] got=%b/%h/%h/%b exp=1/%h/10/0", d, rsv[d],
               rsd[d], rsa[d], rqr[d], hold);
    end
    rsr[d] = 1'b1;
    repeat (6) step();
    nchk++;
    if (on[d] != 3 || ob[d][0] !== 32'h10 || ob[d][1] !== 32'h14 ||
        ob[d][2] !== 32'h18) begin
      nfail++;
      $display("FAIL b2b_order[%0d] count=%0d got=%h,%h,%h exp=3:10,14,18",
               d, on[d], ob[d][0], ob[d][1], ob[d][2]);
    end
  endtask

  task automatic test_flush();
    on[1] = 0;
    rsr[1] = 1'b0;
    push(1, 32'h20);
    push(1, 32'h24);
    step();
    step();
    push(1, 32'h28);
    fl[1] = 1'b1;
    rqv[1] = 1'b1;
    fa[1] = 32'h28;
    #1;
    nchk++;
    if (rqr[1] !== 1'b0) begin
      nfail++;
      $display("FAIL flush_ready got=%b exp=0", rqr[1]);
    end
    step();
    nchk++;
    if (rsv[1] !== 1'b0) begin
      nfail++;
      $display("FAIL flush_valid got=%b exp=0", rsv[1]);
    end
    rsr[1] = 1'b1;
    repeat (5) step();
    nchk++;
    if (on[1] != 1 || ob[1][0] !== 32'h28) begin
      nfail++;
      $display("FAIL flush_stale count=%0d first=%h exp=1:28", on[1], ob[1][0]);
    end
  endtask

  task automatic test_rbw_and_reset();
    len = 1'b1;
    laddr = 32'h0;
    ldata = 32'hCAFEBABE;
    lbe = 4'hF;
    push(0, 32'h0);
    push(1, 32'h0);
    step();
    nchk++;
    if (rsd[0] !== 32'h00c00093) begin
      nfail++;
      $display("FAIL rbw_l1 got=%h exp=00c00093", rsd[0]);
    end
    step();
    nchk++;
    if (rsd[1] !== 32'h00c00093) begin
      nfail++;
      $display("FAIL rbw_l2 got=%h exp=00c00093", rsd[1]);
    end
    push(0, 32'h0);
    step();
    nchk++;
    if (rsd[0] !== 32'hCAFEBABE) begin
      nfail++;
      $display("FAIL rbw_after got=%h exp=cafebabe", rsd[0]);
    end
    push(0, 32'h30);
    push(0, 32'h34);
    push(1, 32'h30);
    push(1, 32'h34);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({rsv[d], rsd[d], rsa[d], rsf[d], lerr[d], rqr[d]} !==
          {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
        nfail++;
        $display("FAIL midreset[%0d] got=%b/%h/%h/%b/%b/%b", d, rsv[d],
                 rsd[d], rsa[d], rsf[d], lerr[d], rqr[d]);
      end
    end
    model_reset();
    rqv[0] = 0;
    rqv[1] = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(0, 32'h0);
    push(1, 32'h0);
    step();
    nchk++;
    if (rsd[0] !== 32'hCAFEBABE) begin
      nfail++;
      $display("FAIL post_reset_l1 got=%h exp=cafebabe", rsd[0]);
    end
    step();
    nchk++;
    if (rsd[1] !== 32'hCAFEBABE) begin
      nfail++;
      $display("FAIL post_reset_l2 got=%h exp=cafebabe", rsd[1]);
    end
    step();
  endtask

  task automatic test_random();
    int r;
    for (int d = 0; d < 2; d++) begin
      sh[d] = 0;
      st[d] = 0;
      on[d] = 0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (sh[d] == st[d] && $urandom_range(3) != 0) begin
          r = $urandom_range(15);
          if (r == 0) push(d, $urandom);
          else if (r == 1) push(d, $urandom_range(1023) | 32'h1);
          else push(d, $urandom_range(255) * 4);
        end
        rsr[d] = ($urandom_range(3) != 0);
        fl[d] = ($urandom_range(31) == 0);
      end
      if ($urandom_range(3) == 0) begin
        len = 1'b1;
        laddr = ($urandom_range(7) == 0) ? 32'h400 + $urandom_range(4095)
                                         : $urandom_range(1023);
        ldata = $urandom;
        lbe = 4'($urandom_range(15));
      end
      step();
    end
    for (int d = 0; d < 2; d++) rsr[d] = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_byte_enable();
    test_faults();
    test_back_to_back(0);
    test_back_to_back(1);
    test_flush();
    test_rbw_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
